// File: rtl/delay_pkg.sv
// Shared types and address arithmetic for the multi-tap delay-line reader.
package delay_pkg;

    localparam int MAX_TAPS  = 16;
    localparam int TAP_CNT_W = $clog2(MAX_TAPS);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } delay_rd_state_t;

    // Circular read index for delay d behind widx. The caller passes
    // d <= len-1, so widx+len-d lies in [1, 2*len-1] and one conditional
    // subtract wraps it. The caller keeps the low AW bits of the result.
    function automatic logic [31:0] delay_addr(input logic [31:0] widx,
                                               input logic [31:0] len,
                                               input logic [31:0] d);
        logic [31:0] sum;
        sum = widx + len - d;
        if (sum >= len) begin
            sum = sum - len;
        end
        return sum;
    endfunction

endpackage

// File: rtl/delay_addr_calc.sv
// Clamps one tap delay to the buffer length and converts it to a BRAM read index.
module delay_addr_calc #(
    parameter int AW = 11
) (
    input  logic [AW-1:0] widx,
    input  logic [AW:0]   len,
    input  logic [AW-1:0] delay,
    output logic [AW-1:0] addr,
    output logic [AW:0]   d_clamped
);
    import delay_pkg::*;

    logic [AW:0] len_m1;

    always_comb begin
        len_m1    = len - (AW+1)'(1);
        d_clamped = ({1'b0, delay} > len_m1) ? len_m1 : {1'b0, delay};
        addr      = AW'(delay_addr(32'(widx), 32'(len), 32'(d_clamped)));
    end

endmodule

// File: rtl/delay_tap_reader.sv
// Reads NTAPS delayed samples per sample tick, one BRAM address per clock,
// and presents them together on tap_out.
module delay_tap_reader #(
    parameter int  WIDTH  = 32,
    parameter int  MAXLEN = 2048,
    parameter int  NTAPS  = 4,
    localparam int AW     = $clog2(MAXLEN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sample_tick,
    input  logic [AW-1:0]          widx,
    input  logic [31:0]            len,
    input  logic [NTAPS*AW-1:0]    tap_delay,
    output logic [AW-1:0]          rd_addr,
    input  logic [WIDTH-1:0]       rd_data,
    output logic [NTAPS*WIDTH-1:0] tap_out,
    output logic                   out_valid,
    output logic                   busy,
    output logic                   overrun
);
    import delay_pkg::*;

    localparam logic [TAP_CNT_W-1:0] K_LAST = TAP_CNT_W'(NTAPS-1);

    delay_rd_state_t state, state_nxt;

    logic [TAP_CNT_W-1:0]    k_q, k_inc;
    logic [AW-1:0]           widx_q;
    logic [AW:0]             len_q, len_in;
    logic [AW:0]             fill_q, fill_lat_q, fill_acc, fill_drop, fill_ref;
    logic [NTAPS*AW-1:0]     delay_q;
    logic signed [WIDTH-1:0] shadow_q [NTAPS];
    logic signed [WIDTH-1:0] cap_data;
    logic                    accept, len_new;
    logic                    tap_vld_p0, tap_vld_p1, tap_vld_p2;

    logic [AW-1:0]           calc_widx, calc_delay, calc_addr;
    logic [AW:0]             calc_len, calc_d;

    // Fill count saturates at the buffer length.
    function automatic logic [AW:0] sat_inc(input logic [AW:0] cnt,
                                            input logic [AW:0] lim);
        return (cnt >= lim) ? lim : cnt + (AW+1)'(1);
    endfunction

    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        accept    = sample_tick && (state == IDLE);
        len_new   = (len != 32'(len_q));
        len_in    = len[AW:0];
        fill_acc  = len_new ? (AW+1)'(1) : sat_inc(fill_q, len_in);
        fill_drop = sat_inc(fill_q, len_q);
        k_inc     = k_q + TAP_CNT_W'(1);
    end

    // Tap 0 is addressed from the live tick inputs; later taps from latched copies.
    always_comb begin
        if (state == IDLE) begin
            calc_widx  = widx;
            calc_len   = len_in;
            calc_delay = tap_delay[AW-1:0];
            fill_ref   = fill_acc;
        end else begin
            calc_widx  = widx_q;
            calc_len   = len_q;
            calc_delay = delay_q[AW-1:0];
            fill_ref   = fill_lat_q;
            for (int i = 1; i < NTAPS; i++) begin
                if (k_inc == TAP_CNT_W'(i)) begin
                    calc_delay = delay_q[i*AW +: AW];
                end
            end
        end
    end

    delay_addr_calc #(
        .AW (AW)
    ) u_addr_calc (
        .widx      (calc_widx),
        .len       (calc_len),
        .delay     (calc_delay),
        .addr      (calc_addr),
        .d_clamped (calc_d)
    );

    assign tap_vld_p0 = (calc_d < fill_ref);
    assign cap_data   = tap_vld_p2 ? rd_data : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sample_tick) state_nxt = ISSUE;
            ISSUE:   if (k_q == K_LAST) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            k_q        <= '0;
            widx_q     <= '0;
            len_q      <= '0;
            fill_q     <= '0;
            fill_lat_q <= '0;
            delay_q    <= '0;
            rd_addr    <= '0;
            tap_vld_p1 <= 1'b0;
            tap_vld_p2 <= 1'b0;
            overrun    <= 1'b0;
            tap_out    <= '0;
            for (int i = 0; i < NTAPS; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state      <= state_nxt;
            tap_vld_p2 <= tap_vld_p1;

            if (accept) begin
                fill_q     <= fill_acc;
                fill_lat_q <= fill_acc;
                widx_q     <= widx;
                len_q      <= len_in;
                delay_q    <= tap_delay;
                k_q        <= '0;
                rd_addr    <= calc_addr;
                tap_vld_p1 <= tap_vld_p0;
            end else if (sample_tick) begin
                fill_q  <= fill_drop;
                overrun <= 1'b1;
            end

            // Stage p1: next tap address and its fill guard.
            if (state == ISSUE) begin
                if (k_q != K_LAST) begin
                    k_q        <= k_inc;
                    rd_addr    <= calc_addr;
                    tap_vld_p1 <= tap_vld_p0;
                end
                // Stage p2: BRAM data for the previous tap.
                for (int i = 0; i < NTAPS-1; i++) begin
                    if (k_q == TAP_CNT_W'(i+1)) begin
                        shadow_q[i] <= cap_data;
                    end
                end
            end

            if (state == DRAIN) begin
                shadow_q[NTAPS-1] <= cap_data;
                for (int i = 0; i < NTAPS-1; i++) begin
                    tap_out[i*WIDTH +: WIDTH] <= shadow_q[i];
                end
                tap_out[(NTAPS-1)*WIDTH +: WIDTH] <= cap_data;
            end
        end
    end

endmodule

// File: tb/tb_delay_tap_reader.sv
// Bench for delay_tap_reader: table vectors, hand-written corner sequences,
// and a scoreboard checking every out_valid against queued expectations.
module tb_delay_tap_reader;

    localparam int WIDTH  = 32;
    localparam int MAXLEN = 2048;
    localparam int NTAPS  = 4;
    localparam int AW     = $clog2(MAXLEN);
    localparam int CW     = NTAPS*WIDTH;
    localparam int TW     = NTAPS*AW;

    logic           clk = 1'b0;
    logic           rst;
    logic           sample_tick;
    logic [AW-1:0]  widx;
    logic [31:0]    len;
    logic [TW-1:0]  tap_delay;
    logic [AW-1:0]  rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic [CW-1:0]  tap_out;
    logic           out_valid;
    logic           busy;
    logic           overrun;

    logic [WIDTH-1:0] mem [MAXLEN];

    typedef struct {
        logic [CW-1:0] val;
        int            due;
        string         name;
    } sb_t;

    typedef struct {
        bit            reset_first;
        int            prefill;
        int            widx;
        int            len;
        logic [TW-1:0] taps;
        logic [TW-1:0] addr;
        logic [CW-1:0] exp;
        string         name;
    } vec_t;

    sb_t  sbq[$];
    sb_t  mon_e;
    vec_t vecs[4];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   ov_count = 0;
    int   fill_m = 0;
    int   len_m = 0;

    delay_tap_reader #(
        .WIDTH  (WIDTH),
        .MAXLEN (MAXLEN),
        .NTAPS  (NTAPS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .widx        (widx),
        .len         (len),
        .tap_delay   (tap_delay),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .tap_out     (tap_out),
        .out_valid   (out_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rd_data <= mem[rd_addr];

    function automatic void chk(input string nm, input logic [CW-1:0] act,
                                input logic [CW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endfunction

    // Reference fill counter.
    function automatic void model_fill_tick(input int l, input bit accepted);
        if (accepted && l != len_m) begin
            fill_m = 1;
            len_m  = l;
        end else begin
            fill_m = (fill_m >= len_m) ? len_m : fill_m + 1;
        end
    endfunction

    always @(negedge clk) begin
        if (out_valid) begin
            ov_count++;
            if (sbq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_out_valid: got out_valid=1 at cycle %0d, expected none", cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk({mon_e.name, "_taps"}, tap_out, mon_e.val);
                chk({mon_e.name, "_cycle"}, CW'(cyc), CW'(mon_e.due));
            end
        end
    end

    task automatic do_reset(input int n);
        rst = 1'b1;
        sample_tick = 1'b0;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
        fill_m = 0;
        len_m  = 0;
        sbq.delete();
    endtask

    // Entered and left one time unit after a rising edge.
    task automatic do_read(input int w, input int l, input logic [TW-1:0] t,
                           input bit use_model, input logic [TW-1:0] ea_in,
                           input logic [CW-1:0] ev_in, input string nm);
        logic [TW-1:0] ea;
        logic [CW-1:0] ev;
        logic [AW-1:0] a;
        int            dc;
        sb_t           e;
        model_fill_tick(l, 1'b1);
        ea = ea_in;
        ev = ev_in;
        if (use_model) begin
            for (int i = 0; i < NTAPS; i++) begin
                dc = int'(t[i*AW +: AW]);
                if (dc > l - 1) dc = l - 1;
                a = AW'((w + l - dc) % l);
                ea[i*AW +: AW] = a;
                ev[i*WIDTH +: WIDTH] = (dc < fill_m) ? mem[a] : '0;
            end
        end
        e.val = ev;
        e.due = cyc + NTAPS + 2;
        e.name = nm;
        sbq.push_back(e);
        widx = AW'(w);
        len = 32'(l);
        tap_delay = t;
        sample_tick = 1'b1;
        @(posedge clk);
        #1 sample_tick = 1'b0;
        for (int i = 0; i < NTAPS; i++) begin
            chk($sformatf("%s_addr%0d", nm, i), CW'(rd_addr), CW'(ea[i*AW +: AW]));
            chk($sformatf("%s_busy%0d", nm, i), CW'(busy), CW'(1));
            @(posedge clk);
            #1;
        end
        chk({nm, "_busy_drain"}, CW'(busy), CW'(1));
        for (int n = 0; n < 8 && sbq.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        if (sbq.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: got no out_valid, expected one", nm);
            sbq.delete();
        end
        chk({nm, "_idle_busy"}, CW'(busy), CW'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            ov0;
        logic [TW-1:0] rt;
        sb_t           e;

        rst = 1'b1;
        sample_tick = 1'b0;
        widx = '0;
        len = '0;
        tap_delay = '0;
        for (int j = 0; j < MAXLEN; j++) mem[j] = WIDTH'(32'h100 + j);

        vecs[0] = '{1'b1, 0, 0, 16, {11'd15, 11'd5, 11'd1, 11'd0},
                    {11'd1, 11'd11, 11'd15, 11'd0},
                    {32'h0, 32'h0, 32'h0, 32'h100}, "first_tick"};
        vecs[1] = '{1'b0, 14, 15, 16, {11'd15, 11'd5, 11'd1, 11'd0},
                    {11'd0, 11'd10, 11'd14, 11'd15},
                    {32'h100, 32'h10A, 32'h10E, 32'h10F}, "steady"};
        vecs[2] = '{1'b1, 2, 2, 16, {11'd15, 11'd5, 11'd1, 11'd0},
                    {11'd3, 11'd13, 11'd1, 11'd2},
                    {32'h0, 32'h0, 32'h101, 32'h102}, "fill_guard"};
        vecs[3] = '{1'b0, 15, 2, 16, {11'd200, 11'd16, 11'd3, 11'd5},
                    {11'd3, 11'd3, 11'd15, 11'd13},
                    {32'h103, 32'h103, 32'h10F, 32'h10D}, "wrap_clamp"};

        @(posedge clk);
        #1;
        do_reset(3);
        chk("reset_rd_addr", CW'(rd_addr), CW'(0));
        chk("reset_tap_out", tap_out, CW'(0));
        chk("reset_out_valid", CW'(out_valid), CW'(0));
        chk("reset_busy", CW'(busy), CW'(0));
        chk("reset_overrun", CW'(overrun), CW'(0));

        for (int v = 0; v < 4; v++) begin
            if (vecs[v].reset_first) do_reset(3);
            for (int k = 0; k < vecs[v].prefill; k++) begin
                for (int i = 0; i < NTAPS; i++) rt[i*AW +: AW] = AW'($urandom_range(0, 20));
                do_read((vecs[v].widx - vecs[v].prefill + k + vecs[v].len) % vecs[v].len,
                        vecs[v].len, rt, 1'b1, '0, '0, "filler");
            end
            do_read(vecs[v].widx, vecs[v].len, vecs[v].taps, 1'b0,
                    vecs[v].addr, vecs[v].exp, vecs[v].name);
        end
        chk("no_overrun_in_spaced_ticks", CW'(overrun), CW'(0));

        // Second tick three cycles into a read is dropped but still counted.
        do_reset(3);
        ov0 = ov_count;
        model_fill_tick(16, 1'b1);
        e.val = {32'h0, 32'h0, 32'h0, 32'h100};
        e.due = cyc + NTAPS + 2;
        e.name = "overrun_read";
        sbq.push_back(e);
        widx = '0;
        len = 32'd16;
        tap_delay = {11'd15, 11'd5, 11'd1, 11'd0};
        sample_tick = 1'b1;
        @(posedge clk);
        #1 sample_tick = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        widx = AW'(1);
        sample_tick = 1'b1;
        model_fill_tick(16, 1'b0);
        @(posedge clk);
        #1 sample_tick = 1'b0;
        chk("overrun_set", CW'(overrun), CW'(1));
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("overrun_single_valid", CW'(ov_count - ov0), CW'(1));
        chk("overrun_sb_drained", CW'(sbq.size()), CW'(0));
        do_read(2, 16, {11'd15, 11'd2, 11'd1, 11'd0}, 1'b0,
                {11'd3, 11'd0, 11'd1, 11'd2},
                {32'h0, 32'h100, 32'h101, 32'h102}, "fill_after_drop");
        chk("overrun_sticky", CW'(overrun), CW'(1));

        // Tick during DONE is dropped.
        do_reset(3);
        chk("overrun_cleared", CW'(overrun), CW'(0));
        ov0 = ov_count;
        model_fill_tick(16, 1'b1);
        e.val = {32'h0, 32'h0, 32'h0, 32'h104};
        e.due = cyc + NTAPS + 2;
        e.name = "done_tick_read";
        sbq.push_back(e);
        widx = AW'(4);
        tap_delay = {11'd15, 11'd5, 11'd1, 11'd0};
        sample_tick = 1'b1;
        @(posedge clk);
        #1 sample_tick = 1'b0;
        repeat (NTAPS + 1) begin
            @(posedge clk);
            #1;
        end
        widx = AW'(5);
        sample_tick = 1'b1;
        model_fill_tick(16, 1'b0);
        @(posedge clk);
        #1 sample_tick = 1'b0;
        chk("done_tick_busy", CW'(busy), CW'(0));
        chk("done_tick_overrun", CW'(overrun), CW'(1));
        chk("done_tick_valid_count", CW'(ov_count - ov0), CW'(1));

        // Reset three cycles into a read aborts it.
        do_reset(3);
        ov0 = ov_count;
        widx = AW'(9);
        sample_tick = 1'b1;
        @(posedge clk);
        #1 sample_tick = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        fill_m = 0;
        len_m = 0;
        chk("abort_busy", CW'(busy), CW'(0));
        chk("abort_out_valid", CW'(out_valid), CW'(0));
        chk("abort_tap_out", tap_out, CW'(0));
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        do_read(5, 16, {11'd15, 11'd5, 11'd1, 11'd0}, 1'b0,
                {11'd6, 11'd0, 11'd4, 11'd5},
                {32'h0, 32'h0, 32'h0, 32'h105}, "after_abort");
        chk("abort_valid_count", CW'(ov_count - ov0), CW'(1));

        // Tick coincident with reset is ignored.
        rst = 1'b1;
        sample_tick = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sample_tick = 1'b0;
        fill_m = 0;
        len_m = 0;
        chk("tick_with_rst_busy", CW'(busy), CW'(0));
        @(posedge clk);
        #1;
        chk("tick_with_rst_still_idle", CW'(busy), CW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/delay_tap_reader.md
# delay_tap_reader

Multi-tap read side of a BRAM sample delay line. On every sample tick from the writer it fetches NTAPS delayed samples from the BRAM read port, one address per clock, and presents them together on a registered output bus. It feeds the reverb/comb and echo stages, which need several delays of one shared buffer per sample period.

## Interface
- WIDTH, 32, sample width in bits
- MAXLEN, 2048, BRAM depth; AW = $clog2(MAXLEN) is the address width
- NTAPS, 4, number of taps read per sample, 1..16
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- sample_tick  in  1  one-cycle pulse: writer has just stored a sample at widx
- widx  in  AW  write index of that sample; sampled only with sample_tick
- len  in  32  circular buffer length, 2..MAXLEN; sampled only with sample_tick
- tap_delay  in  NTAPS*AW  per-tap delay in samples; tap i is bits [i*AW +: AW]; sampled with sample_tick
- rd_addr  out  AW  BRAM read address, registered
- rd_data  in  WIDTH  BRAM read data, valid one clk after rd_addr
- tap_out  out  NTAPS*WIDTH  delayed samples; tap i is bits [i*WIDTH +: WIDTH]
- out_valid  out  1  one-cycle pulse: tap_out has just been updated
- busy  out  1  high from the cycle after the accepted tick through the out_valid cycle
- overrun  out  1  sticky; a tick arrived while busy

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on sample_tick, latch widx, len and tap_delay, increment fill, zero the tap counter, go to ISSUE.
- ISSUE: drive rd_addr for tap k and capture rd_data for tap k-1 (for k > 0). After tap NTAPS-1, go to DRAIN.
- DRAIN: capture rd_data for tap NTAPS-1, go to DONE.
- DONE: copy the shadow registers to tap_out, pulse out_valid, go to IDLE.
- tap_out changes only in DONE, so all taps update together.
- Address per tap:
  - d = min(tap_delay[i], len-1).
  - rd_addr = (widx + len - d) mod len, computed at AW+1 bits. A single conditional subtract is enough; no divider.
  - d = 0 reads the sample just written.
- Fill guard:
  - fill counts sample_ticks since reset, including dropped ones, saturating at the latched len.
  - Tap i's captured value is forced to 0 unless d < fill.
  - This blocks stale or uninitialised BRAM contents from reaching the output.
- A sample_tick in any state other than IDLE is dropped and sets overrun. fill still increments.
- A new len that differs from the previous len resets fill to 1, because the buffer geometry has changed.

## Timing
- Tick high in cycle 0:
  - rd_addr for tap i is valid in cycle 1+i.
  - rd_data for tap i is captured at the end of cycle 2+i.
  - tap_out and out_valid change in cycle NTAPS+2.
- Minimum tick spacing without overrun is NTAPS+3 cycles.
- busy is high in cycles 1..NTAPS+2.
- Reset values:
  - rd_addr = 0, tap_out = 0, out_valid = 0, busy = 0, overrun = 0.
  - fill = 0, state IDLE, shadow registers = 0.
- Reset during any state aborts immediately: no out_valid, tap_out = 0.
- A tick in the same cycle as rst is ignored.
- A tick in the DONE cycle is dropped and counts as overrun.

## Structure
- Package delay_pkg holds:
  - the state enum delay_rd_state_t;
  - the function delay_addr(widx, len, d) returning AW bits;
  - the constant MAX_TAPS = 16.
- One sub-module, delay_addr_calc: combinational clamp plus modulo address, using the package function, instanced once and shared across taps.
- The BRAM itself is instanced by the parent, next to the writer.

## Test plan
- Reset: hold rst for 3 cycles, then release.
  - Expect all outputs 0 and state IDLE.
  - Fire a tick with fill 0 and taps {0,1,5,15}: the result is all zero except tap0 = sample[widx].
- Steady state, len=16, taps {0,1,5,15}, BRAM[j] = 0x100+j, after 16 ticks with widx=15.
  - Expect rd_addr sequence 15,14,10,0 in cycles 1..4.
  - Expect tap_out {0x10F,0x10E,0x10A,0x100} and out_valid in cycle 6.
- Fill guard: after 3 ticks (widx=2), same taps.
  - Expect tap_out {0x102,0x101,0,0}.
- Wrap-around: full buffer, widx=2, taps {5,3,16,200}.
  - Expect addresses 13, 15, 3, 3; the last two are clamped to d=15.
- Overrun: ticks in cycles 0 and 3 with NTAPS=4.
  - Expect exactly one out_valid, in cycle 6, and overrun=1 held until rst.
  - fill still advances by 2.
- Reset mid-read: rst in cycle 3 after a tick.
  - Expect no out_valid, tap_out=0, busy=0 the next cycle.
  - A tick 2 cycles later is accepted normally.
